// File: rtl/multu_pkg.sv
// ============================================================================
// Module   : multu_pkg
// Purpose  : Shared constants and FSM state encoding for the iterative
//            multiply/divide units of the execute stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multu_pkg;

  localparam int MULTU_WIDTH = 32;
  localparam int MULTU_CNT_W = 5;

  // Also used by the iterative divider, so both units share one handshake shape.
  typedef enum logic [0:0] {
    MULTU_IDLE = 1'b0,
    MULTU_CALC = 1'b1
  } multu_state_e;

endpackage

`default_nettype wire

// File: rtl/multu_step.sv
// ============================================================================
// Module   : multu_step
// Purpose  : One radix-2 shift-add iteration of the unsigned multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multu_step
  import multu_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] p_next
);

  logic [WIDTH:0] sum;

  // The extra sum bit holds the carry, which the right shift drops into the MSB.
  always_comb begin
    sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    p_next = {sum, p[WIDTH-1:1]};
  end

endmodule

`default_nettype wire

// File: rtl/multu.sv
// ============================================================================
// Module   : multu
// Purpose  : Sequential unsigned WIDTHxWIDTH multiplier with start/busy/done.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multu
  import multu_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH,
  parameter int CNT_W = MULTU_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  multu_state_e          state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0]    p_q, p_d;
  logic [WIDTH-1:0]      m_q, m_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [2*WIDTH-1:0]    p_step;

  multu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p_q),
    .m      (m_q),
    .p_next (p_step)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    m_d     = m_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      MULTU_IDLE: begin
        if (start) begin
          state_d = MULTU_CALC;
          m_d     = multiplicand;
          p_d     = {{WIDTH{1'b0}}, multiplier};
          count_d = '0;
          busy_d  = 1'b1;
        end
      end
      MULTU_CALC: begin
        p_d     = p_step;
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = MULTU_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = MULTU_IDLE;
    endcase
  end

  // The CPU pipeline advances on the rising edge; this unit updates on the falling one.
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q <= MULTU_IDLE;
      count_q <= '0;
      p_q     <= '0;
      m_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      m_q     <= m_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign hi   = p_q[2*WIDTH-1:WIDTH];
  assign lo   = p_q[WIDTH-1:0];
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_multu.sv
// ============================================================================
// Module   : tb_multu
// Purpose  : Scoreboard bench for the sequential unsigned multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multu;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  logic [63:0] st_p;
  logic [31:0] st_m;
  logic [63:0] st_next;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  multu dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done)
  );

  multu_step #(.WIDTH(32)) u_step_chk (
    .p      (st_p),
    .m      (st_m),
    .p_next (st_next)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: outputs change on the falling edge, so sample on the rising edge.
  int          busy_cnt = 0;
  logic        prev_done = 1'b0;
  logic [63:0] exp_v;
  always @(posedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got result 0x%0h expected none", {hi, lo});
      end else begin
        exp_v = exp_q.pop_front();
        chk("hi", {32'h0, hi}, {32'h0, exp_v[63:32]});
        chk("lo", {32'h0, lo}, {32'h0, exp_v[31:0]});
        chk("latency", 64'(busy_cnt), 64'd32);
        chk("busy_at_done", {63'h0, busy}, 64'd0);
      end
      chk("done_one_cycle", {63'h0, prev_done}, 64'd0);
      busy_cnt = 0;
    end else if (busy === 1'b1) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: busy=%b after %0d cycles expected 0", busy, n);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] req);
    wait_idle();
    @(posedge clock);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    exp_q.push_back(req);
    @(posedge clock);
    start = 1'b0;
    wait_idle();
    @(posedge clock);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    st_p         = '0;
    st_m         = '0;
    repeat (3) @(posedge clock);
    chk("reset_hi",   {32'h0, hi}, 64'd0);
    chk("reset_lo",   {32'h0, lo}, 64'd0);
    chk("reset_busy", {63'h0, busy}, 64'd0);
    chk("reset_done", {63'h0, done}, 64'd0);
    reset = 1'b0;

    // Single-step datapath vectors.
    st_p = 64'h0000_0000_0000_0003; st_m = 32'd5; #1;
    chk("step_odd", st_next, 64'h0000_0002_8000_0001);
    st_p = 64'hFFFF_FFFF_FFFF_FFFF; st_m = 32'hFFFF_FFFF; #1;
    chk("step_carry", st_next, 64'hFFFF_FFFF_7FFF_FFFF);
    st_p = 64'h0000_0001_0000_0002; st_m = 32'hFFFF_FFFF; #1;
    chk("step_even", st_next, 64'h0000_0000_8000_0001);

    issue(32'd3,          32'd5,          64'h0000_0000_0000_000F);
    issue(32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
    issue(32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000);
    issue(32'd0,          32'h1234_5678,  64'h0);
    issue(32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF);
    issue(32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000);

    // Start raised mid-flight is ignored, then held to launch the next op.
    wait_idle();
    @(posedge clock);
    start = 1'b1; multiplicand = 32'd7; multiplier = 32'd9;
    exp_q.push_back(64'd63);
    @(posedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
    exp_q.push_back(64'd4);
    begin
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
        @(posedge clock);
        n++;
      end
      if (n >= 200) begin
        checks++; failures++;
        $display("FAIL wait_done: done=%b expected 1", done);
      end
    end
    @(posedge clock);
    chk("back_to_back_busy", {63'h0, busy}, 64'd1);
    start = 1'b0;
    wait_idle();
    @(posedge clock);

    // Reset mid-operation abandons it without exposing a partial result.
    @(posedge clock);
    start = 1'b1; multiplicand = 32'h0000_ABCD; multiplier = 32'h0000_1234;
    @(posedge clock);
    start = 1'b0;
    repeat (14) @(posedge clock);
    reset = 1'b1;
    @(posedge clock);
    chk("abort_busy", {63'h0, busy}, 64'd0);
    chk("abort_done", {63'h0, done}, 64'd0);
    chk("abort_hi",   {32'h0, hi}, 64'd0);
    chk("abort_lo",   {32'h0, lo}, 64'd0);
    reset = 1'b0;
    issue(32'd6, 32'd7, 64'd42);

    // Reset wins over start on the same edge.
    reset = 1'b1; start = 1'b1; multiplicand = 32'd3; multiplier = 32'd3;
    @(posedge clock);
    chk("rst_start_busy", {63'h0, busy}, 64'd0);
    chk("rst_start_lo",   {32'h0, lo}, 64'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clock);
    chk("rst_start_idle", {63'h0, busy}, 64'd0);

    repeat (3) @(posedge clock);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
